// File: rtl/fifo_rd_ctrl.sv
// Burst read controller for a FIFO with one-cycle read latency, feeding a 2-entry
// in-order skid buffer toward a valid/ready sink, with sticky error flags.

module fifo_rd_ctrl_chk #(
    parameter int data_width = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  rd_en,
    input logic                  fifo_empty,
    input logic                  in_read,
    input logic [1:0]            occ,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [data_width-1:0] out_data,
    input logic                  burst_done,
    input logic                  err_underflow,
    input logic                  err_protocol
);
    a_rd_en_legal: assert property (@(posedge clk) disable iff (rst)
        rd_en |-> (in_read && !fifo_empty));
    a_occ_max: assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) burst_done |=> !burst_done);
    a_uf_sticky: assert property (@(posedge clk) disable iff (rst) err_underflow |=> err_underflow);
    a_pe_sticky: assert property (@(posedge clk) disable iff (rst) err_protocol |=> err_protocol);
endmodule

module fifo_rd_ctrl #(
    parameter int data_width = 8,
    parameter int burst_len  = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    input  logic                  fifo_valid,
    input  logic                  fifo_underflow,
    output logic                  rd_en,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  burst_done,
    output logic [15:0]           word_count,
    output logic                  err_underflow,
    output logic                  err_protocol
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [7:0] burst_len_c = 8'(burst_len);

    state_t                state_q, state_d;
    logic [7:0]            issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [data_width-1:0] buf0_q, buf0_d;
    logic [data_width-1:0] buf1_q, buf1_d;
    logic [15:0]           word_count_q, word_count_d;
    logic                  err_underflow_q, err_underflow_d;
    logic                  err_protocol_q, err_protocol_d;
    logic                  rst_dly_q, rst_dly_d;

    logic                  out_valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  lost_s;
    logic [2:0]            level_s;
    logic                  space_ok_s;
    logic                  burst_end_s;

    // Handshake strobes derived from registered state and the FIFO response
    always_comb begin
        out_valid_s = (occ_q != 2'd0) && !rst;
        pop_s       = out_valid_s && out_ready;
        push_s      = fifo_valid && inflight_q;
        lost_s      = inflight_q && !fifo_valid;
        level_s     = {1'b0, occ_q} + {2'b00, inflight_q};
        space_ok_s  = level_s < ({2'b00, pop_s} + 3'd2);
        burst_end_s = (state_q == DRAIN) && !inflight_q && (occ_q == 2'd0)
                      && (issued_q >= burst_len_c);
    end

    // FSM state register
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a read lost after the last issue sends DRAIN back to READ
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (issued_d == burst_len_c) begin
                    state_d = DRAIN;
                end else begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                if (issued_q < burst_len_c) begin
                    state_d = READ;
                end else if (burst_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: read request throttled by buffer space, end-of-burst pulse
    always_comb begin
        rd_en      = !rst && (state_q == READ) && !fifo_empty
                     && (issued_q < burst_len_c) && space_ok_s;
        burst_done = !rst && burst_end_s;
    end

    // Issue counter, skid buffer, transfer counter and sticky error flags
    always_comb begin
        if (state_q == IDLE) begin
            issued_d = 8'd0;
        end else begin
            issued_d = issued_q + {7'd0, rd_en} - {7'd0, lost_s};
        end

        inflight_d = rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = occ_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    buf1_d = fifo_data;
                    occ_d  = 2'd2;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                end else begin
                    buf0_d = buf0_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end
            end
            default: occ_d = occ_q;
        endcase

        word_count_d    = word_count_q + {15'd0, pop_s};
        err_underflow_d = err_underflow_q || fifo_underflow || lost_s;
        // Data answering a read issued before reset is dropped silently
        err_protocol_d  = err_protocol_q || (fifo_valid && !inflight_q && !rst_dly_q);
        rst_dly_d       = 1'b0;
    end

    // Datapath registers
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            issued_q        <= 8'd0;
            inflight_q      <= 1'b0;
            occ_q           <= 2'd0;
            buf0_q          <= {data_width{1'b0}};
            buf1_q          <= {data_width{1'b0}};
            word_count_q    <= 16'h0000;
            err_underflow_q <= 1'b0;
            err_protocol_q  <= 1'b0;
            rst_dly_q       <= 1'b1;
        end else begin
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            occ_q           <= occ_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            word_count_q    <= word_count_d;
            err_underflow_q <= err_underflow_d;
            err_protocol_q  <= err_protocol_d;
            rst_dly_q       <= rst_dly_d;
        end
    end

    assign out_valid     = out_valid_s;
    assign out_data      = rst ? {data_width{1'b0}} : buf0_q;
    assign word_count    = rst ? 16'h0000 : word_count_q;
    assign err_underflow = !rst && err_underflow_q;
    assign err_protocol  = !rst && err_protocol_q;

    fifo_rd_ctrl_chk #(.data_width(data_width)) u_chk (
        .clk          (rd_clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .fifo_empty   (fifo_empty),
        .in_read      (state_q == READ),
        .occ          (occ_q),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .burst_done   (burst_done),
        .err_underflow(err_underflow),
        .err_protocol (err_protocol)
    );
endmodule
